spi_controller: RTL

SPI initiator that serialises 16-bit write frames to the chip's SPI register peripheral. Drives `sclk`, `ncs` and `copi` from the system clock. Used by bring-up logic and testbenches to program the output-enable, PWM-enable and duty-cycle registers. Frames are requested through a valid/ready handshake.

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_controller_if.sv | 23 ++
 rtl/spi_tick_gen.sv | 30 +++
 rtl/spi_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared frame width, register-map addresses, frame builder and FSM
// state type for spi_controller.
// Optional feature macro: SPI_CTRL_COMMIT_PULSE_EN. When it is defined, the
// commit states are part of the state type.
package spi_pkg;

    localparam int unsigned SPI_FRAME_W = 16;

    // Register map of the SPI peripheral; other addresses are sent as-is.
    localparam logic [6:0] SPI_ADDR_EN_OUT_UO  = 7'h00;
    localparam logic [6:0] SPI_ADDR_EN_OUT_UIO = 7'h01;
    localparam logic [6:0] SPI_ADDR_EN_PWM_UO  = 7'h02;
    localparam logic [6:0] SPI_ADDR_EN_PWM_UIO = 7'h03;
    localparam logic [6:0] SPI_ADDR_PWM_DUTY   = 7'h04;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StSetup    = 3'd1,
        StShift    = 3'd2,
        StHold     = 3'd3,
        StDeassert = 3'd4
`ifdef SPI_CTRL_COMMIT_PULSE_EN
        ,
        StCommitHi = 3'd5,
        StCommitLo = 3'd6
`endif
    } spi_ctrl_state_t;

    // Write frame: the write flag in bit 15, then the address, then the data.
    function automatic logic [SPI_FRAME_W-1:0] spi_frame(input logic [6:0] addr,
                                                         input logic [7:0] data);
        return {1'b1, addr, data};
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// spi_controller_if: request handshake plus SPI pins of the controller.
// The master side issues requests and watches the pins; the slave side is the
// controller.
interface spi_controller_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       done;
    logic       sclk;
    logic       ncs;
    logic       copi;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, done, sclk, ncs, copi
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, done, sclk, ncs, copi
    );
endinterface

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: half-period divider. o_tick is high in the last cycle of each
// CLK_DIV-cycle half period; i_restart forces the count back to zero.
module spi_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned     CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] r_cnt;

    // Divider count: wraps at CntMax, cleared on restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == CntMax)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == CntMax);

endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator that sends 16-bit write frames
// {1, addr[6:0], data[7:0]} MSB first. Every SPI pin comes straight from a
// flop.
// Optional feature macro: SPI_CTRL_COMMIT_PULSE_EN. When it is defined, every
// frame ends with one sclk pulse while ncs is high.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_controller_if.slave   bus
);

    spi_ctrl_state_t        r_state, w_state_d;
    logic [SPI_FRAME_W-2:0] r_shift, w_shift_d;
    logic [3:0]             r_bit_cnt, w_bit_cnt_d;
    logic                   r_phase, w_phase_d;  // 0: sclk-high half, 1: sclk-low half
    logic                   r_sclk, w_sclk_d;
    logic                   r_ncs, w_ncs_d;
    logic                   r_copi, w_copi_d;
    logic                   r_done, w_done_d;
    logic [SPI_FRAME_W-1:0] w_frame;
    logic                   w_tick;
    logic                   w_restart;

    assign w_frame = spi_frame(bus.req_addr, bus.req_data);

    // The divider restarts on every state change and stays at zero while idle.
    assign w_restart = (w_state_d != r_state) || (r_state == StIdle);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state plus the next values of the datapath and the registered pins.
    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_bit_cnt_d = r_bit_cnt;
        w_phase_d   = r_phase;
        w_sclk_d    = r_sclk;
        w_ncs_d     = r_ncs;
        w_copi_d    = r_copi;
        w_done_d    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.req_valid) begin
                    w_state_d   = StSetup;
                    w_shift_d   = w_frame[SPI_FRAME_W-2:0];
                    w_copi_d    = w_frame[SPI_FRAME_W-1];
                    w_ncs_d     = 1'b0;
                    w_sclk_d    = 1'b0;
                    w_bit_cnt_d = 4'd0;
                    w_phase_d   = 1'b0;
                end
            end
            StSetup: begin
                if (w_tick) begin
                    w_state_d = StShift;
                    w_sclk_d  = 1'b1;
                    w_phase_d = 1'b0;
                end
            end
            StShift: begin
                if (w_tick) begin
                    if (!r_phase) begin
                        // Falling edge. copi advances here, except after the last bit.
                        w_sclk_d = 1'b0;
                        if (r_bit_cnt == 4'd15) begin
                            w_state_d   = StHold;
                            w_bit_cnt_d = 4'd0;
                        end else begin
                            w_phase_d   = 1'b1;
                            w_bit_cnt_d = r_bit_cnt + 4'd1;
                            w_copi_d    = r_shift[SPI_FRAME_W-2];
                            w_shift_d   = {r_shift[SPI_FRAME_W-3:0], 1'b0};
                        end
                    end else begin
                        w_phase_d = 1'b0;
                        w_sclk_d  = 1'b1;
                    end
                end
            end
            StHold: begin
                if (w_tick) begin
                    w_state_d = StDeassert;
                    w_ncs_d   = 1'b1;
                end
            end
            StDeassert: begin
                if (w_tick) begin
`ifdef SPI_CTRL_COMMIT_PULSE_EN
                    w_state_d = StCommitHi;
                    w_sclk_d  = 1'b1;
`else
                    w_state_d = StIdle;
                    w_copi_d  = 1'b0;
                    w_done_d  = 1'b1;
`endif
                end
            end
`ifdef SPI_CTRL_COMMIT_PULSE_EN
            StCommitHi: begin
                if (w_tick) begin
                    w_state_d = StCommitLo;
                    w_sclk_d  = 1'b0;
                end
            end
            StCommitLo: begin
                if (w_tick) begin
                    w_state_d = StIdle;
                    w_copi_d  = 1'b0;
                    w_done_d  = 1'b1;
                end
            end
`endif
            default: begin
                w_state_d   = StIdle;
                w_sclk_d    = 1'b0;
                w_ncs_d     = 1'b1;
                w_copi_d    = 1'b0;
                w_bit_cnt_d = 4'd0;
                w_phase_d   = 1'b0;
            end
        endcase
    end

    // Datapath and output flops. Reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= 4'd0;
            r_phase   <= 1'b0;
            r_sclk    <= 1'b0;
            r_ncs     <= 1'b1;
            r_copi    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_shift   <= w_shift_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_phase   <= w_phase_d;
            r_sclk    <= w_sclk_d;
            r_ncs     <= w_ncs_d;
            r_copi    <= w_copi_d;
            r_done    <= w_done_d;
        end
    end

    assign bus.req_ready = (r_state == StIdle);
    assign bus.done      = r_done;
    assign bus.sclk      = r_sclk;
    assign bus.ncs       = r_ncs;
    assign bus.copi      = r_copi;

endmodule
